// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
//
// Turns a simple core-side word access (instruction or data port) into one
// single-beat AXI4 read or write transaction. Only one transaction is ever
// outstanding. The core is stalled until the slave's response has been
// received. Then a one-cycle resp_done pulse returns the read data and an
// error flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid                core request present, held until resp_done
//   req_write                1 = write, 0 = read
//   req_strb                 byte enables for writes (active high)
//   req_addr                 byte address; the low two bits are ignored
//   req_wdata                write data
//   stall                    req_valid & ~resp_done
//   resp_done                one-cycle completion pulse
//   resp_rdata, resp_err     read data and error flag, valid with resp_done
//   AR*/R*                   AXI read address / read data channels
//   AW*/W*/B*                AXI write address / data / response channels
//
// Every AXI VALID/READY output comes straight from a flop. The AXI inputs only
// affect next-state logic, so no slave signal reaches a handshake output in
// the same cycle.
// ---------------------------------------------------------------------------
module axi_master_bridge #(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = '0,
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,

  // core side
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                resp_done,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,

  // read address channel
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,

  // read data channel
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,

  // write address channel
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,

  // write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,

  // write response channel
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } state_t;

  state_t              state;

  // Request fields captured at accept time. The core holds them stable, but
  // latching them keeps the AXI address and data independent of the core.
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;

  // Registered handshake outputs
  logic                ar_valid_q;
  logic                r_ready_q;
  logic                aw_valid_q;
  logic                w_valid_q;
  logic                b_ready_q;

  // Sticky flags: each one records that its write channel has already
  // handshaken. This lets AW and W complete in either order or together.
  logic                aw_done;
  logic                w_done;

  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  // Write-phase handshakes, including the ones completing in this cycle
  logic                aw_hs;
  logic                w_hs;
  logic                aw_fin;
  logic                w_fin;

  assign aw_hs  = aw_valid_q & AWREADY;
  assign w_hs   = w_valid_q & WREADY;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  // The low address bits are dropped at capture time. The bus therefore only
  // ever sees word-aligned addresses, and unaligned requests are not flagged
  // as errors.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr & WORD_MASK;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            if (req_write) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= S_WR;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= S_AR;
            end
          end
        end

        S_AR: begin
          if (ar_valid_q && ARREADY) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= S_R;
          end
        end

        S_R: begin
          if (RVALID) begin
            rdata_q   <= RDATA;
            // A single-beat read must be last. It must also carry our ID.
            err_q     <= (RRESP != 2'b00) | ~RLAST | (RID != MASTER_ID);
            r_ready_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_WR: begin
          // Each VALID drops on its own handshake. It does not wait for the
          // other channel.
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done    <= 1'b1;
          end
          // These assignments come last so that they override the flag sets
          // above when the final handshake happens in this cycle.
          if (aw_fin && w_fin) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            b_ready_q <= 1'b1;
            state     <= S_B;
          end
        end

        S_B: begin
          if (BVALID) begin
            err_q     <= (BRESP != 2'b00) | (BID != MASTER_ID);
            b_ready_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          // The error flag is cleared here, so resp_err is only ever high
          // during the resp_done pulse.
          done_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Core-side outputs
  assign stall      = req_valid & ~done_q;
  assign resp_done  = done_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  // Read address channel: single INCR beat of one full word
  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = ar_valid_q;
  assign RREADY  = r_ready_q;

  // Write channels
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = aw_valid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = strb_q;
  assign WLAST   = w_valid_q;
  assign WVALID  = w_valid_q;
  assign BREADY  = b_ready_q;

endmodule

// File: tb/tb_axi_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_master_bridge
//
// Bench for axi_master_bridge. It contains:
//   - A driver that issues core requests.
//   - A cycle-level AXI slave whose response timing is set per transaction.
//   - A scoreboard monitor. At issue time the driver pushes the expected
//     result, computed from the transaction description. The monitor pops it
//     on each resp_done.
// All bench activity happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_master_bridge;

  localparam int         ID_W   = 4;
  localparam int         ADDR_W = 32;
  localparam int         DATA_W = 32;
  localparam logic [3:0] MID    = 4'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;

  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [3:0]        req_strb  = '0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              stall, resp_done, resp_err;
  logic [DATA_W-1:0] resp_rdata;

  logic [ID_W-1:0]   ARID, AWID;
  logic [ADDR_W-1:0] ARADDR, AWADDR;
  logic [3:0]        ARLEN, AWLEN;
  logic [2:0]        ARSIZE, AWSIZE;
  logic [1:0]        ARBURST, AWBURST;
  logic              ARVALID, AWVALID, RREADY, WVALID, WLAST, BREADY;
  logic [DATA_W-1:0] WDATA;
  logic [3:0]        WSTRB;

  logic              ARREADY = 1'b0;
  logic              AWREADY = 1'b0;
  logic              WREADY  = 1'b0;
  logic [ID_W-1:0]   RID     = '0;
  logic [DATA_W-1:0] RDATA   = '0;
  logic [1:0]        RRESP   = '0;
  logic              RLAST   = 1'b0;
  logic              RVALID  = 1'b0;
  logic [ID_W-1:0]   BID     = '0;
  logic [1:0]        BRESP   = '0;
  logic              BVALID  = 1'b0;

  always #5 clk = ~clk;

  axi_master_bridge #(
    .ID_W(ID_W), .MASTER_ID(MID), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_strb(req_strb),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // A transaction: the core request plus the slave's timing and response.
  // The delays count falling edges the slave waits before it answers.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [1:0]  resp;
    bit          last;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    int          b_dly;
    bit          w_after_aw;   // slave raises WREADY only after the AW handshake
  } txn_t;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    bit          err;
    int          ar_cyc;
    int          aw_cyc;
    int          w_cyc;
  } exp_t;

  txn_t cur;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  // ----- reference model ---------------------------------------------------
  // Expected result and VALID durations of a transaction. Each VALID stays
  // high from its first cycle until its own handshake. Under w_after_aw, the
  // W wait only starts once AW has handshaken.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    e.wr    = t.wr;
    e.rdata = t.rdata;
    if (!t.wr) begin
      e.err    = (t.resp != 2'b00) || !t.last || (t.id != MID);
      e.ar_cyc = t.ar_dly + 1;
      e.aw_cyc = 0;
      e.w_cyc  = 0;
    end else begin
      e.err    = (t.resp != 2'b00) || (t.id != MID);
      e.ar_cyc = 0;
      e.aw_cyc = t.aw_dly + 1;
      e.w_cyc  = t.w_after_aw ? t.aw_dly + t.w_dly + 2 : t.w_dly + 1;
    end
    return e;
  endfunction

  // Falling edges from driving req_valid to seeing resp_done. The minimum is
  // 3: accept, address phase, response phase.
  function automatic int latency(input txn_t t);
    int wterm;
    if (!t.wr) return 3 + t.ar_dly + t.r_dly;
    wterm = t.w_after_aw ? t.aw_dly + 1 + t.w_dly : t.w_dly;
    return 3 + t.b_dly + ((t.aw_dly > wterm) ? t.aw_dly : wterm);
  endfunction

  function automatic txn_t base_txn(input bit wr, input logic [31:0] addr);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = '0; t.rdata = '0; t.strb = 4'hF;
    t.id = MID; t.resp = 2'b00; t.last = 1'b1;
    t.ar_dly = 0; t.aw_dly = 0; t.w_dly = 0; t.r_dly = 0; t.b_dly = 0;
    t.w_after_aw = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t = base_txn(1'($urandom_range(0, 1)), $urandom);
    t.wdata      = $urandom;
    t.rdata      = $urandom;
    t.strb       = 4'($urandom_range(0, 15));
    t.id         = ($urandom_range(0, 7) == 0) ? MID + 4'd1 : MID;
    t.resp       = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    t.last       = ($urandom_range(0, 7) != 0);
    t.ar_dly     = $urandom_range(0, 3);
    t.aw_dly     = $urandom_range(0, 3);
    t.w_dly      = $urandom_range(0, 3);
    t.r_dly      = $urandom_range(0, 3);
    t.b_dly      = $urandom_range(0, 3);
    t.w_after_aw = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // ----- AXI slave ---------------------------------------------------------
  bit ar_seen, aw_seen, w_seen, aw_hs_done, w_hs_done, r_phase, b_phase;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;

  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rst) begin
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        RLAST = 0; RDATA = '0;
        ar_seen = 0; aw_seen = 0; w_seen = 0; aw_hs_done = 0; w_hs_done = 0;
        r_phase = 0; b_phase = 0;
      end else begin
        // AR: a READY driven last edge means the handshake just took place.
        if (ARREADY) begin
          ARREADY = 0;
          check("arvalid_drop", ARVALID, 0);
          r_phase = 1;
          r_cnt   = cur.r_dly;
        end else if (ARVALID) begin
          if (!ar_seen) begin
            ar_seen = 1;
            ar_cnt  = cur.ar_dly;
            check("araddr", ARADDR, {cur.addr[31:2], 2'b00});
            check("ar_fields", {ARID, ARLEN, ARSIZE, ARBURST}, {MID, 4'd0, 3'd2, 2'd1});
          end
          if (ar_cnt == 0) begin ARREADY = 1; ar_seen = 0; end
          else ar_cnt--;
        end
        // R
        if (RVALID) begin
          RVALID = 0; RLAST = 0; RDATA = '0;
        end else if (r_phase) begin
          if (r_cnt == 0) begin
            check("rready", RREADY, 1);
            RVALID = 1; RDATA = cur.rdata; RRESP = cur.resp;
            RLAST = cur.last; RID = cur.id;
            r_phase = 0;
          end else r_cnt--;
        end
        // AW
        if (AWREADY) begin
          AWREADY = 0;
          check("awvalid_drop", AWVALID, 0);
          aw_hs_done = 1;
        end else if (AWVALID) begin
          if (!aw_seen) begin
            aw_seen = 1;
            aw_cnt  = cur.aw_dly;
            check("awaddr", AWADDR, {cur.addr[31:2], 2'b00});
            check("aw_fields", {AWID, AWLEN, AWSIZE, AWBURST}, {MID, 4'd0, 3'd2, 2'd1});
          end
          if (aw_cnt == 0) begin AWREADY = 1; aw_seen = 0; end
          else aw_cnt--;
        end
        // W
        if (WREADY) begin
          WREADY = 0;
          check("wvalid_drop", WVALID, 0);
          w_hs_done = 1;
        end else if (WVALID && (!cur.w_after_aw || aw_hs_done)) begin
          if (!w_seen) begin
            w_seen = 1;
            w_cnt  = cur.w_dly;
            check("w_fields", {WDATA, WSTRB, WLAST}, {cur.wdata, cur.strb, 1'b1});
          end
          if (w_cnt == 0) begin WREADY = 1; w_seen = 0; end
          else w_cnt--;
        end
        // B
        if (aw_hs_done && w_hs_done) begin
          aw_hs_done = 0; w_hs_done = 0;
          b_phase = 1;
          b_cnt   = cur.b_dly;
        end
        if (BVALID) begin
          BVALID = 0;
        end else if (b_phase) begin
          if (b_cnt == 0) begin
            check("bready", BREADY, 1);
            BVALID = 1; BID = cur.id; BRESP = cur.resp;
            b_phase = 0;
          end else b_cnt--;
        end
      end
    end
  end

  // ----- scoreboard monitor ------------------------------------------------
  int arc, awc, wc;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arc = 0; awc = 0; wc = 0;
      end else begin
        if (ARVALID) arc++;
        if (AWVALID) awc++;
        if (WVALID)  wc++;
        if (resp_done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: resp_done seen, no transaction outstanding (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            if (!e.wr) check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", resp_err, e.err);
            check("arvalid_cycles", arc, e.ar_cyc);
            check("awvalid_cycles", awc, e.aw_cyc);
            check("wvalid_cycles", wc, e.w_cyc);
          end
          arc = 0; awc = 0; wc = 0;
        end
      end
    end
  end

  // ----- driver ------------------------------------------------------------
  // Must be called on a falling edge, at which req is driven. It returns one
  // edge after resp_done. At that point req_valid has been dropped, or is
  // left high when keep is set so that the next request follows at once.
  task automatic run_txn(input txn_t t, input bit keep);
    int n, first_v;
    bit stall_ok;
    cur = t;
    exp_q.push_back(model(t));
    req_valid = 1; req_write = t.wr; req_addr = t.addr;
    req_wdata = t.wdata; req_strb = t.strb;
    #1 check("stall_at_accept", stall, 1);
    n = 0; first_v = 0; stall_ok = 1;
    forever begin
      @(negedge clk);
      n++;
      if (first_v == 0 && (ARVALID || AWVALID)) first_v = n;
      if (resp_done) break;
      if (!stall) stall_ok = 0;
      if (n >= 300) begin
        n_checks++;
        n_err++;
        $display("FAIL timeout: no resp_done after %0d cycles", n);
        finish_sim();
      end
    end
    check("latency", n, latency(t));
    check("first_valid_offset", first_v, 1);
    check("stall_held", stall_ok, 1);
    check("stall_at_done", stall, 0);
    @(negedge clk);
    if (!keep) req_valid = 0;
  endtask

  initial begin : watchdog
    #500000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin : driver
    txn_t t;
    int   n;
    bit   quiet;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_handshakes", {ARVALID, RREADY, AWVALID, WVALID, BREADY, resp_done, resp_err}, 7'd0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_latched", {ARADDR, WDATA, WSTRB}, 68'd0);
    rst = 1;
    repeat (2) @(negedge clk);

    // Zero-wait read
    t = base_txn(0, 32'h0000_1004);
    t.rdata = 32'hDEAD_BEEF;
    run_txn(t, 0);
    @(negedge clk);

    // Write, AWREADY delayed 3 cycles, WREADY immediate
    t = base_txn(1, 32'h0000_2008);
    t.wdata = 32'h1234_5678; t.strb = 4'b0011; t.aw_dly = 3;
    run_txn(t, 0);
    @(negedge clk);

    // Write where the slave takes AW first, then W
    t = base_txn(1, 32'h0000_2008);
    t.wdata = 32'h1234_5678; t.strb = 4'b0011; t.aw_dly = 2; t.w_after_aw = 1;
    run_txn(t, 0);
    @(negedge clk);

    // Error paths
    t = base_txn(0, 32'h0000_3000); t.rdata = 32'hA5A5_0001; t.resp = 2'b10;
    run_txn(t, 0);
    t = base_txn(1, 32'h0000_3004); t.wdata = 32'h0BAD_F00D; t.id = MID + 4'd1;
    run_txn(t, 0);
    t = base_txn(0, 32'h0000_3008); t.rdata = 32'h5A5A_0002; t.last = 0;
    run_txn(t, 0);

    // Back-to-back read then write with req_valid held
    t = base_txn(0, 32'h0000_4000); t.rdata = 32'h1111_2222;
    run_txn(t, 1);
    t = base_txn(1, 32'h0000_4004); t.wdata = 32'h3333_4444; t.strb = 4'b1100;
    run_txn(t, 0);

    // Zero strobes are still issued; unaligned address, no error
    t = base_txn(1, 32'h0000_5001); t.wdata = 32'hCAFE_0000; t.strb = 4'b0000;
    run_txn(t, 0);
    t = base_txn(0, 32'h0000_5007); t.rdata = 32'h7777_8888;
    run_txn(t, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit keep;
      keep = ($urandom_range(0, 2) == 0);
      run_txn(rand_txn(), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    // Reset while the read data phase is waiting. No completion is expected,
    // so nothing is pushed onto the scoreboard.
    t = base_txn(0, 32'h0000_6000); t.rdata = 32'h0F0F_0F0F; t.r_dly = 6;
    cur = t;
    req_valid = 1; req_write = 0; req_addr = t.addr;
    n = 0;
    while (!RREADY && n < 20) begin @(negedge clk); n++; end
    check("reached_r_phase", RREADY, 1);
    #2 rst = 0;
    #1;
    check("async_rst_handshakes", {ARVALID, RREADY, AWVALID, WVALID, BREADY, resp_done, resp_err}, 7'd0);
    check("async_rst_rdata", resp_rdata, 0);
    check("async_rst_latched", {ARADDR, WDATA, WSTRB}, 68'd0);
    req_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    quiet = 1;
    repeat (10) begin
      @(negedge clk);
      if (ARVALID || AWVALID || WVALID || RREADY || BREADY || resp_done) quiet = 0;
    end
    check("idle_after_reset", quiet, 1);
    check("stall_after_reset", stall, 0);

    finish_sim();
  end

endmodule
